// File: rtl/one_to_five_dispatch_pkg.sv
// Shared dynamic-node definitions: port count, route select coding, length field and dispatch FSM states.
package one_to_five_dispatch_pkg;

  localparam int unsigned NUM_PORTS    = 5;
  localparam int unsigned SEL_W        = 3;
  localparam logic [2:0]  NULL_SEL_MIN = 3'd5;
  localparam int unsigned LEN_W        = 8;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } state_t;

  function automatic logic is_null_sel(input logic [SEL_W-1:0] sel);
    return sel >= NULL_SEL_MIN;
  endfunction

endpackage

// File: rtl/one_to_five_dispatch_credit_counter.sv
// Per-output credit counter: starts full, consumed by sends, refilled by yummy returns.
module dispatch_credit_counter #(
  parameter  int unsigned CREDITS = 4,
  localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          consume,
  input  logic          yummy,
  output logic [CW-1:0] count,
  output logic          nonzero
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({consume, yummy})
      2'b10:   count_d = count_q - CW'(1);
      // A yummy at full credit is a protocol error; hold rather than wrap.
      2'b01:   if (count_q != CW'(CREDITS)) count_d = count_q + CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= CW'(CREDITS);
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign nonzero = (count_q != '0);

endmodule

// File: rtl/one_to_five_dispatch.sv
// One-input, five-output packet dispatcher with per-output credit flow control.
module one_to_five_dispatch
  import one_to_five_dispatch_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned LEN_LSB = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic [2:0]       sel_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic [4:0]       valid_out,
  input  logic [4:0]       yummy_in
);

  localparam int unsigned CW = $clog2(CREDITS + 1);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       route_q, route_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [WIDTH-1:0]       data_out_q, data_out_d;
  logic [NUM_PORTS-1:0]   valid_out_q, valid_out_d;

  logic [SEL_W-1:0]       target;
  logic                   target_null;
  logic                   accept;
  logic                   send;
  logic [NUM_PORTS-1:0]   consume;
  logic [NUM_PORTS-1:0]   nonzero;
  logic [7:0]             nonzero_pad;
  logic [CW-1:0]          count [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_credit
    dispatch_credit_counter #(
      .CREDITS (CREDITS)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .consume (consume[g]),
      .yummy   (yummy_in[g]),
      .count   (count[g]),
      .nonzero (nonzero[g])
    );
  end

  // Padding lets null selects 5..7 index safely; they never gate readiness.
  assign nonzero_pad = {3'b000, nonzero};
  assign target      = (state_q == HEAD) ? sel_in : route_q;
  assign target_null = is_null_sel(target);
  assign ready_out   = target_null | nonzero_pad[target];
  assign accept      = valid_in & ready_out;
  assign send        = accept & ~target_null;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      consume[i] = send && (target == SEL_W'(i));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      assert (nonzero[i] == (count[i] != '0));
    end
  end

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    remaining_d = remaining_q;
    data_out_d  = send ? data_in : data_out_q;
    valid_out_d = consume;
    if (accept) begin
      case (state_q)
        HEAD: begin
          route_d     = sel_in;
          remaining_d = data_in[LEN_LSB +: LEN_W];
          if (data_in[LEN_LSB +: LEN_W] != '0) state_d = BODY;
        end
        BODY: begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = HEAD;
        end
        default: state_d = HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HEAD;
      route_q     <= '0;
      remaining_q <= '0;
      data_out_q  <= '0;
      valid_out_q <= '0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      remaining_q <= remaining_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule
